// File: rtl/control_sequencer.sv
// control_sequencer: fetches 16-bit instructions over valid/ready, decodes one
// control word per instruction for the datapath, resolves conditional branches
// from the datapath status flags and maintains the program counter.
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | instr_ready=1, waiting for a valid instruction word
// EXEC  | IR decoded; control word presented for one cycle; pc updated
// TEST  | branch only: status flags sampled, pc takes offset or pc+1
// HALT  | halted=1, instructions ignored until reset
module control_sequencer #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [15:0]         instr,
  output logic                instr_ready,
  output logic [PC_WIDTH-1:0] pc,
  output logic                cw_valid,
  output logic [3:0]          fs,
  output logic [2:0]          da,
  output logic [2:0]          aa,
  output logic [2:0]          ba,
  output logic                mb,
  output logic [15:0]         constant,
  output logic                rw,
  input  logic                zero_in,
  input  logic                negative_in,
  output logic                halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    TEST  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_BRZ = 4'hA;
  localparam logic [3:0] OP_BRN = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t                state, state_nxt;
  logic [15:0]           ir;
  logic [PC_WIDTH-1:0]   pc_nxt;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [PC_WIDTH-1:0]   pc_jmp;
  logic [PC_WIDTH-1:0]   offset;
  logic [3:0]            opcode;
  logic [2:0]            dr, sa, sb, imm;
  logic                  taken;

  assign opcode = ir[15:12];
  assign dr     = ir[11:9];
  assign sa     = ir[8:6];
  assign sb     = ir[5:3];
  assign imm    = ir[2:0];

  // {DR,imm} is a 6-bit signed offset; PC_WIDTH must be at least 6
  assign offset = {{(PC_WIDTH-6){dr[2]}}, dr, imm};
  assign pc_inc = pc + PC_WIDTH'(1);
  assign pc_jmp = pc + offset;

  // BRZ tests zero, BRN tests negative; IR still holds the branch in TEST
  assign taken  = (opcode == OP_BRZ) ? zero_in : negative_in;

  function automatic logic [3:0] fs_decode(input logic [3:0] op);
    case (op)
      4'h0:    fs_decode = 4'b0000;
      4'h1:    fs_decode = 4'b0001;
      4'h2:    fs_decode = 4'b0010;
      4'h3:    fs_decode = 4'b0101;
      4'h4:    fs_decode = 4'b0110;
      4'h5:    fs_decode = 4'b1000;
      4'h6:    fs_decode = 4'b1001;
      4'h7:    fs_decode = 4'b1010;
      4'h8:    fs_decode = 4'b1011;
      4'h9:    fs_decode = 4'b1100;
      default: fs_decode = 4'b0000;
    endcase
  endfunction

  // state, pc and instruction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == FETCH && instr_valid)
        ir <= instr;
    end
  end

  // next-state, pc update and control word decode from registered state
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instr_ready = 1'b0;
    halted      = 1'b0;
    cw_valid    = 1'b0;
    fs          = 4'b0000;
    da          = 3'd0;
    aa          = 3'd0;
    ba          = 3'd0;
    mb          = 1'b0;
    constant    = 16'h0000;
    rw          = 1'b0;
    case (state)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid)
          state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = FETCH;
        pc_nxt    = pc_inc;
        if (opcode <= OP_LDI) begin
          cw_valid = 1'b1;
          rw       = 1'b1;
          fs       = fs_decode(opcode);
          da       = dr;
          aa       = sa;
          ba       = sb;
          if (opcode == OP_LDI) begin
            mb       = 1'b1;
            constant = {13'b0, imm};
          end
        end else if (opcode == OP_BRZ || opcode == OP_BRN) begin
          // pass A through the function unit so its flags reflect R[SA]
          cw_valid  = 1'b1;
          da        = dr;
          aa        = sa;
          ba        = sb;
          pc_nxt    = pc;
          state_nxt = TEST;
        end else if (opcode == OP_JMP) begin
          pc_nxt = pc_jmp;
        end else if (opcode == OP_HLT) begin
          pc_nxt    = pc;
          state_nxt = HALT;
        end
      end
      TEST: begin
        state_nxt = FETCH;
        pc_nxt    = taken ? pc_jmp : pc_inc;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  pc;
  logic        cw_valid;
  logic [3:0]  fs;
  logic [2:0]  da, aa, ba;
  logic        mb;
  logic [15:0] constant;
  logic        rw;
  logic        zero_in, negative_in;
  logic        halted;

  int vectors = 0;
  int errors  = 0;

  logic [30:0] exp_q[$];

  control_sequencer #(.PC_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .pc         (pc),
    .cw_valid   (cw_valid),
    .fs         (fs),
    .da         (da),
    .aa         (aa),
    .ba         (ba),
    .mb         (mb),
    .constant   (constant),
    .rw         (rw),
    .zero_in    (zero_in),
    .negative_in(negative_in),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [30:0] cw(input logic [3:0] f, input logic [2:0] d,
                                     input logic [2:0] a, input logic [2:0] b,
                                     input logic m, input logic [15:0] k,
                                     input logic w);
    return {f, d, a, b, m, k, w};
  endfunction

  // scoreboard monitor: every presented control word must match the next expectation
  always @(negedge clk) begin
    if (cw_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cw", {1'b0, fs, da, aa, ba, mb, constant, rw}, 32'hFFFF_FFFF);
      end else begin
        chk("control_word", {1'b0, fs, da, aa, ba, mb, constant, rw}, {1'b0, exp_q.pop_front()});
      end
    end else begin
      chk("idle_fields", {1'b0, fs, da, aa, ba, mb, constant, rw}, 32'h0);
    end
  end

  // one accepting handshake; returns 1 time unit after the capturing edge (DUT in EXEC)
  task automatic send(input logic [15:0] w);
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_ready", 32'(instr_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic branch(input logic [15:0] w, input logic z, input logic n,
                        input logic [7:0] exp_pc, input string name);
    exp_q.push_back(cw(4'b0000, w[11:9], w[8:6], w[5:3], 1'b0, 16'h0, 1'b0));
    send(w);
    chk({name, "_exec_ready"}, 32'(instr_ready), 32'h0);
    zero_in     = z;
    negative_in = n;
    step();
    chk({name, "_test_ready"}, 32'(instr_ready), 32'h0);
    step();
    chk({name, "_pc"}, 32'(pc), 32'(exp_pc));
    zero_in     = 1'b0;
    negative_in = 1'b0;
  endtask

  logic [3:0]  fs_tab [0:8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b0110,
                                4'b1000, 4'b1001, 4'b1010, 4'b1011};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0;
    zero_in     = 1'b0;
    negative_in = 1'b0;
    #1;
    chk("init_pc", 32'(pc), 32'h0);
    chk("init_ready", 32'(instr_ready), 32'h1);
    chk("init_halted", 32'(halted), 32'h0);
    chk("init_cw_valid", 32'(cw_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ADD R3,R1,R2
    exp_q.push_back(cw(4'b0010, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0, 1'b1));
    send(16'h2650);
    chk("add_exec_pc", 32'(pc), 32'h0);
    step();
    chk("add_pc", 32'(pc), 32'h1);
    chk("add_ready", 32'(instr_ready), 32'h1);

    // LDI R5,#7
    exp_q.push_back(cw(4'b1100, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0007, 1'b1));
    send(16'h9A07);
    step();
    chk("ldi_pc", 32'(pc), 32'h2);

    // all ALU opcodes, imm nonzero so constant must stay 0
    for (int i = 0; i < 9; i++) begin
      w = {4'(i), 3'(i), 3'(i + 3), 3'(7 - i), 3'd5};
      exp_q.push_back(cw(fs_tab[i], 3'(i), 3'(i + 3), 3'(7 - i), 1'b0, 16'h0, 1'b1));
      send(w);
      step();
      chk("alu_pc", 32'(pc), 32'(3 + i));
    end

    // NOPs walk pc from 0 to 5
    do_reset();
    send(16'hD000); step();
    send(16'hE123); step();
    send(16'hD000); step();
    send(16'hE000); step();
    send(16'hDFFF); step();
    chk("nop_pc", 32'(pc), 32'h5);

    // branches from pc=5, offset -2
    branch(16'hAE86, 1'b1, 1'b0, 8'h03, "brz_taken");
    send(16'hC002); step();
    chk("jmp_fwd_pc", 32'(pc), 32'h5);
    branch(16'hAE86, 1'b0, 1'b1, 8'h06, "brz_not_taken");
    send(16'hCE07); step();
    chk("jmp_back_pc", 32'(pc), 32'h5);
    branch(16'hBE86, 1'b0, 1'b1, 8'h03, "brn_taken");
    branch(16'hBE86, 1'b1, 1'b0, 8'h04, "brn_not_taken");

    // stall: no valid words for 4 cycles
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_ready", 32'(instr_ready), 32'h1);
      chk("stall_cw_valid", 32'(cw_valid), 32'h0);
      chk("stall_pc", 32'(pc), 32'h4);
    end

    // wrap: JMP -2 from 0 -> 0xFE, then JMP +3 -> 0x01
    do_reset();
    send(16'hCE06); step();
    chk("jmp_neg_wrap_pc", 32'(pc), 32'hFE);
    send(16'hC003); step();
    chk("jmp_wrap_pc", 32'(pc), 32'h01);

    // HALT
    send(16'hF000);
    step();
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_ready", 32'(instr_ready), 32'h0);
    chk("halt_pc", 32'(pc), 32'h01);
    instr       = 16'h2650;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_hold_halted", 32'(halted), 32'h1);
      chk("halt_hold_ready", 32'(instr_ready), 32'h0);
      chk("halt_hold_pc", 32'(pc), 32'h01);
    end
    instr_valid = 1'b0;
    do_reset();

    // async reset mid-EXEC of an ADD
    send(16'hD000); step();
    chk("pre_abort_pc", 32'(pc), 32'h1);
    send(16'h2650);
    chk("abort_cw_before", 32'(cw_valid), 32'h1);
    chk("abort_rw_before", 32'(rw), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_cw_valid", 32'(cw_valid), 32'h0);
    chk("abort_rw", 32'(rw), 32'h0);
    chk("abort_pc", 32'(pc), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("abort_ready", 32'(instr_ready), 32'h1);
    chk("abort_pc_after", 32'(pc), 32'h0);

    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
